// File: rtl/multiplier_pkg.sv
// Shared constants for the sequential Booth multiplier: state encodings and
// default operand/counter widths, used by the datapath and the next-state logic.
package multiplier_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CNT_W = 6;

    typedef logic [1:0] state_t;

    localparam state_t INIT    = 2'b00;
    localparam state_t OPERATE = 2'b01;
    localparam state_t DONE    = 2'b11;

    // Encodings other than the three legal states collapse to INIT.
    function automatic state_t legalise_state(input logic [1:0] s);
        case (s)
            INIT, OPERATE, DONE: legalise_state = s;
            default:             legalise_state = INIT;
        endcase
    endfunction

endpackage

// File: rtl/multiplier_booth_dp_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into the
// accumulator followed by an arithmetic right shift of {A,Q,q_1}.
module booth_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q_1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_1_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign m_ext = {m_i[WIDTH-1], m_i};

    always_comb begin
        sum = a_i;
        case ({q_i[0], q_1_i})
            2'b01:   sum = a_i + m_ext;
            2'b10:   sum = a_i - m_ext;
            default: sum = a_i;
        endcase
    end

    assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q_1_o = q_i[0];

endmodule

// File: rtl/multiplier_booth_dp.sv
// State register, iteration counter and Booth datapath registers of the
// sequential multiplier; next state comes from the external multiplier_ns.
module multiplier_booth_dp
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           n_state,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     cnt,
    output logic [2*WIDTH-1:0]   result,
    output logic                 op_done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_1_q, q_1_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic             step_q_1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .q_1_i (q_1_q),
        .m_i   (m_q),
        .a_o   (step_a),
        .q_o   (step_q),
        .q_1_o (step_q_1)
    );

    assign state_d = legalise_state(n_state);

    always_comb begin
        m_d   = m_q;
        a_d   = a_q;
        q_d   = q_q;
        q_1_d = q_1_q;
        cnt_d = cnt_q;
        if (state_d == INIT) begin
            m_d   = '0;
            a_d   = '0;
            q_d   = '0;
            q_1_d = 1'b0;
            cnt_d = '0;
        end else if (state_q == INIT && state_d == OPERATE) begin
            m_d   = multiplicand;
            a_d   = '0;
            q_d   = multiplier;
            q_1_d = 1'b0;
            cnt_d = '0;
        end else if (state_q == OPERATE) begin
            // Counter wraps to zero on the last step, so DONE shows cnt=0.
            a_d   = step_a;
            q_d   = step_q;
            q_1_d = step_q_1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q_1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q_1_q   <= q_1_d;
        end
    end

    assign state   = state_q;
    assign cnt     = cnt_q;
    assign result  = {a_q[WIDTH-1:0], q_q};
    assign op_done = (state_q == DONE);

endmodule
